// File: rtl/mem_access_unit.sv
// Memory access unit: MAR/MDR register pair driving a single-request memory port
// with byte/word sizing, alignment fault detection and a bounded ready wait.
module mem_access_unit #(
  parameter int DATA_W   = 16,
  parameter int ADDR_W   = 16,
  parameter int WAIT_MAX = 15
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  LD_MAR,
  input  logic                  LD_MDR,
  input  logic                  MIO_EN,
  input  logic                  R_W,
  input  logic                  DATA_SIZE,
  input  logic [DATA_W-1:0]     bus_in,
  output logic [DATA_W-1:0]     mdr_out,
  output logic [ADDR_W-1:0]     MAR,
  output logic                  R,
  output logic                  fault,
  output logic                  timeout,
  output logic                  mem_en,
  output logic [ADDR_W-1:0]     mem_addr,
  output logic [DATA_W/8-1:0]   mem_we,
  output logic [DATA_W-1:0]     mem_wdata,
  input  logic [DATA_W-1:0]     mem_rdata,
  input  logic                  mem_ready,
  output logic [1:0]            dbg_state
);

  localparam int NB    = DATA_W / 8;
  localparam int LB    = $clog2(NB);
  localparam int CNT_W = $clog2(WAIT_MAX + 1);

  typedef enum logic [1:0] {IDLE = 2'd0, BUSY = 2'd1, DONE = 2'd2, ERR = 2'd3} state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] mar_q;
  logic [DATA_W-1:0] mdr_q;
  logic [CNT_W-1:0]  cnt_q;
  logic              rw_q, sz_q, err_to_q;
  logic [LB-1:0]     off_q;
  logic              unaligned;
  logic              last_wait;
  logic [7:0]        byte_sel;

  // Handshake: MIO_EN is a one-cycle request honoured only in IDLE; mem_en stays
  // high through BUSY until mem_ready is sampled high or the wait budget runs out,
  // and R then pulses for exactly one cycle (with fault/timeout naming the cause).
  assign unaligned = DATA_SIZE && (mar_q[LB-1:0] != '0);
  assign last_wait = (cnt_q == CNT_W'(WAIT_MAX - 1));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= IDLE;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (MIO_EN) state_d = unaligned ? ERR : BUSY;
      BUSY: begin
        if (mem_ready)      state_d = DONE;
        else if (last_wait) state_d = ERR;
      end
      DONE:    state_d = IDLE;
      ERR:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    mem_en  = 1'b0;
    mem_we  = '0;
    R       = 1'b0;
    fault   = 1'b0;
    timeout = 1'b0;
    case (state_q)
      BUSY: begin
        mem_en = 1'b1;
        if (rw_q) mem_we = sz_q ? {NB{1'b1}} : (NB'(1) << off_q);
      end
      DONE: R = 1'b1;
      ERR: begin
        R       = 1'b1;
        fault   = !err_to_q;
        timeout = err_to_q;
      end
      default: ;
    endcase
  end

  // Register datapath; every load is gated by the current state so stray
  // control inputs outside IDLE/BUSY leave MAR and MDR untouched.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mar_q    <= '0;
      mdr_q    <= '0;
      cnt_q    <= '0;
      rw_q     <= 1'b0;
      sz_q     <= 1'b1;
      off_q    <= '0;
      err_to_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (LD_MAR) mar_q <= bus_in[ADDR_W-1:0];
          if (LD_MDR && !MIO_EN) mdr_q <= bus_in;
          if (MIO_EN) begin
            if (unaligned) begin
              err_to_q <= 1'b0;
            end else begin
              rw_q  <= R_W;
              sz_q  <= DATA_SIZE;
              off_q <= mar_q[LB-1:0];
              cnt_q <= '0;
            end
          end
        end
        BUSY: begin
          if (mem_ready) begin
            if (!rw_q) mdr_q <= mem_rdata;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
            if (last_wait) err_to_q <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign mem_addr  = {mar_q[ADDR_W-1:LB], {LB{1'b0}}};
  assign mem_wdata = sz_q ? mdr_q : {NB{mdr_q[7:0]}};
  assign MAR       = mar_q;
  assign dbg_state = state_q;

  always_comb begin
    byte_sel = 8'h00;
    for (int i = 0; i < NB; i++) begin
      if (mar_q[LB-1:0] == LB'(i)) byte_sel = mdr_q[8*i +: 8];
    end
    mdr_out = sz_q ? mdr_q : {{(DATA_W-8){byte_sel[7]}}, byte_sel};
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// Bench for mem_access_unit: vector table of complete accesses, random byte
// reads, and hand-written sequences for reset, ignored controls and stray ready.
module tb_mem_access_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        LD_MAR = 1'b0, LD_MDR = 1'b0, MIO_EN = 1'b0, R_W = 1'b0, DATA_SIZE = 1'b0;
  logic [15:0] bus_in = '0;
  logic [15:0] mdr_out, MAR, mem_addr, mem_wdata;
  logic [15:0] mem_rdata = '0;
  logic        mem_ready = 1'b0;
  logic        R, fault, timeout, mem_en;
  logic [1:0]  mem_we;
  logic [1:0]  dbg_state;

  mem_access_unit #(.DATA_W(16), .ADDR_W(16), .WAIT_MAX(15)) dut (
    .clk(clk), .rst(rst), .LD_MAR(LD_MAR), .LD_MDR(LD_MDR), .MIO_EN(MIO_EN),
    .R_W(R_W), .DATA_SIZE(DATA_SIZE), .bus_in(bus_in), .mdr_out(mdr_out), .MAR(MAR),
    .R(R), .fault(fault), .timeout(timeout), .mem_en(mem_en), .mem_addr(mem_addr),
    .mem_we(mem_we), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .mem_ready(mem_ready), .dbg_state(dbg_state)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] addr;
    logic        rw;
    logic        size;
    logic [15:0] mdr;
    logic [15:0] rdata;
    int          delay;
    logic [15:0] exp_addr;
    logic [1:0]  exp_we;
    logic [15:0] exp_wdata;
    logic [15:0] exp_out;
    logic        exp_fault;
    logic        exp_to;
    int          exp_lat;
  } vec_t;

  vec_t        vecs[10];
  logic [17:0] exp_q[$];
  int          n_cmp = 0;
  int          n_err = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic check_result();
    logic [17:0] e;
    if (exp_q.size() == 0) begin
      check("result_queue_empty", 32'd1, 32'd0);
    end else begin
      e = exp_q.pop_front();
      check("result", {14'd0, fault, timeout, mdr_out}, {14'd0, e});
    end
  endtask

  task automatic run_vec(input vec_t v);
    int n, k;
    logic seen_en, done;
    @(negedge clk);
    LD_MAR = 1'b1; bus_in = v.addr;
    @(negedge clk);
    LD_MAR = 1'b0; LD_MDR = 1'b1; bus_in = v.mdr;
    @(negedge clk);
    LD_MDR = 1'b0; MIO_EN = 1'b1; R_W = v.rw; DATA_SIZE = v.size; mem_rdata = v.rdata;
    exp_q.push_back({v.exp_fault, v.exp_to, v.exp_out});
    n = 0; k = 0; seen_en = 1'b0; done = 1'b0;
    while (!done && n < 40) begin
      @(negedge clk);
      MIO_EN = 1'b0;
      n++;
      if (R) begin
        mem_ready = 1'b0;
        done = 1'b1;
        check("latency", n, v.exp_lat);
        check("mem_en_seen", {31'd0, seen_en}, {31'd0, !v.exp_fault});
        check_result();
        @(negedge clk);
        check("r_one_cycle", {31'd0, R}, 32'd0);
      end else if (mem_en) begin
        if (!seen_en) begin
          check("mem_addr", {16'd0, mem_addr}, {16'd0, v.exp_addr});
          check("mem_we", {30'd0, mem_we}, {30'd0, v.exp_we});
          if (v.rw) check("mem_wdata", {16'd0, mem_wdata}, {16'd0, v.exp_wdata});
        end
        seen_en = 1'b1;
        mem_ready = (k == v.delay);
        k++;
      end
    end
    if (!done) begin
      check("r_wait_expired", 32'd1, 32'd0);
      mem_ready = 1'b0;
      if (exp_q.size() > 0) void'(exp_q.pop_front());
    end
  endtask

  initial begin
    vec_t        v;
    logic [15:0] a, d;
    logic [7:0]  b;
    int          dl;

    vecs[0] = '{16'h3000, 1'b0, 1'b1, 16'h0000, 16'hBEEF, 0,  16'h3000, 2'b00, 16'h0000, 16'hBEEF, 1'b0, 1'b0, 2};
    vecs[1] = '{16'h3001, 1'b1, 1'b0, 16'h12A5, 16'h0000, 0,  16'h3000, 2'b10, 16'hA5A5, 16'h0012, 1'b0, 1'b0, 2};
    vecs[2] = '{16'h4001, 1'b0, 1'b0, 16'h0000, 16'h80FF, 1,  16'h4000, 2'b00, 16'h0000, 16'hFF80, 1'b0, 1'b0, 3};
    vecs[3] = '{16'h4000, 1'b0, 1'b0, 16'h0000, 16'h80FF, 2,  16'h4000, 2'b00, 16'h0000, 16'hFFFF, 1'b0, 1'b0, 4};
    vecs[4] = '{16'h5002, 1'b1, 1'b1, 16'hC3C3, 16'h0000, 0,  16'h5002, 2'b11, 16'hC3C3, 16'hC3C3, 1'b0, 1'b0, 2};
    vecs[5] = '{16'h2003, 1'b0, 1'b1, 16'h5A5A, 16'h0000, 0,  16'h0000, 2'b00, 16'h0000, 16'h5A5A, 1'b1, 1'b0, 1};
    vecs[6] = '{16'h6000, 1'b1, 1'b0, 16'h7F3C, 16'h0000, 3,  16'h6000, 2'b01, 16'h3C3C, 16'h003C, 1'b0, 1'b0, 5};
    vecs[7] = '{16'h7000, 1'b0, 1'b1, 16'h1234, 16'hFFFF, 99, 16'h7000, 2'b00, 16'h0000, 16'h1234, 1'b0, 1'b1, 16};
    vecs[8] = '{16'h7000, 1'b0, 1'b1, 16'h0000, 16'h8001, 14, 16'h7000, 2'b00, 16'h0000, 16'h8001, 1'b0, 1'b0, 16};
    vecs[9] = '{16'h3001, 1'b1, 1'b0, 16'h0080, 16'h0000, 0,  16'h3000, 2'b10, 16'h8080, 16'h0000, 1'b0, 1'b0, 2};

    // Reset state
    repeat (2) @(negedge clk);
    check("rst_mar", {16'd0, MAR}, 32'd0);
    check("rst_mdr_out", {16'd0, mdr_out}, 32'd0);
    check("rst_ctrl", {27'd0, R, fault, timeout, mem_en, 1'b0}, 32'd0);
    check("rst_we", {30'd0, mem_we}, 32'd0);
    check("rst_state", {30'd0, dbg_state}, 32'd0);
    rst = 1'b1;

    for (int i = 0; i < 10; i++) run_vec(vecs[i]);

    // Random byte reads against a sign-extension model
    for (int i = 0; i < 6; i++) begin
      a  = 16'($urandom_range(0, 65535));
      d  = 16'($urandom_range(0, 65535));
      dl = $urandom_range(0, 5);
      b  = a[0] ? d[15:8] : d[7:0];
      v  = '{a, 1'b0, 1'b0, 16'h0000, d, dl, a & 16'hFFFE, 2'b00, 16'h0000,
             {{8{b[7]}}, b}, 1'b0, 1'b0, dl + 2};
      run_vec(v);
    end

    // mem_ready while IDLE is ignored
    @(negedge clk);
    d = mdr_out;
    mem_ready = 1'b1; mem_rdata = 16'h1111;
    repeat (2) @(negedge clk);
    check("idle_ready_r", {31'd0, R}, 32'd0);
    check("idle_ready_state", {30'd0, dbg_state}, 32'd0);
    check("idle_ready_mdr", {16'd0, mdr_out}, {16'd0, d});
    mem_ready = 1'b0;

    // LD_MAR / LD_MDR / MIO_EN during BUSY are ignored
    LD_MAR = 1'b1; bus_in = 16'h3000;
    @(negedge clk);
    LD_MAR = 1'b0; MIO_EN = 1'b1; R_W = 1'b0; DATA_SIZE = 1'b1;
    @(negedge clk);
    MIO_EN = 1'b0; LD_MAR = 1'b1; bus_in = 16'hAAAA;
    check("busy_entered", {31'd0, mem_en}, 32'd1);
    @(negedge clk);
    LD_MAR = 1'b0; LD_MDR = 1'b1; MIO_EN = 1'b1; bus_in = 16'h5555;
    check("busy_ld_mar_ignored", {16'd0, MAR}, 32'h3000);
    check("busy_mem_addr", {16'd0, mem_addr}, 32'h3000);
    @(negedge clk);
    LD_MDR = 1'b0; MIO_EN = 1'b0; mem_ready = 1'b1; mem_rdata = 16'h0F0F;
    exp_q.push_back({1'b0, 1'b0, 16'h0F0F});
    @(negedge clk);
    mem_ready = 1'b0;
    if (R) check_result();
    else check("busy_ignore_r", {31'd0, R}, 32'd1);
    check("busy_mar_hold", {16'd0, MAR}, 32'h3000);

    // Reset in the middle of a word write
    @(negedge clk);
    LD_MAR = 1'b1; bus_in = 16'h1234;
    @(negedge clk);
    LD_MAR = 1'b0; LD_MDR = 1'b1; bus_in = 16'h9999;
    @(negedge clk);
    LD_MDR = 1'b0; MIO_EN = 1'b1; R_W = 1'b1; DATA_SIZE = 1'b1;
    @(negedge clk);
    MIO_EN = 1'b0;
    check("pre_rst_we", {30'd0, mem_we}, 32'd3);
    #2 rst = 1'b0;
    #1;
    check("rst_busy_en", {31'd0, mem_en}, 32'd0);
    check("rst_busy_we", {30'd0, mem_we}, 32'd0);
    check("rst_busy_mar", {16'd0, MAR}, 32'd0);
    check("rst_busy_mdr", {16'd0, mdr_out}, 32'd0);
    @(negedge clk);
    rst = 1'b1; mem_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("no_r_after_rst", {31'd0, R}, 32'd0);
    end
    mem_ready = 1'b0;

    // Normal access after reset release
    run_vec(vecs[0]);

    check("queue_drained", exp_q.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/mem_access_unit.md
MEM_ACCESS_UNIT -- requirements
Module: mem_access_unit

Interface
REQ-001 SHALL have parameter DATA_W, default 16, meaning data width; power of two, >= 16.
REQ-002 SHALL have parameter ADDR_W, default 16, meaning address width.
REQ-003 SHALL have parameter WAIT_MAX, default 15, meaning maximum wait cycles before timeout; >= 1.
REQ-004 SHALL derive localparams NB = DATA_W/8 (byte lanes) and LB = log2(NB).
REQ-005 SHALL have one clock; reset is asynchronous and active-low. Ports: clk  in  1  clock; rst  in  1  asynchronous active-low reset.
REQ-006 SHALL have ports: LD_MAR  in  1  load MAR from bus_in; LD_MDR  in  1  load MDR from bus_in when MIO_EN=0.
REQ-007 SHALL have ports: MIO_EN  in  1  start memory access; R_W  in  1  1=write, 0=read; DATA_SIZE  in  1  1=word, 0=byte.
REQ-008 SHALL have ports: bus_in  in  DATA_W  bus value; mdr_out  out  DATA_W  MDR bus-drive value; MAR  out  ADDR_W  address register.
REQ-009 SHALL have ports: R  out  1  access-complete pulse; fault  out  1  unaligned-word pulse; timeout  out  1  no-ready pulse.
REQ-010 SHALL have memory ports: mem_en  out  1; mem_addr  out  ADDR_W; mem_we  out  NB  byte write enables; mem_wdata  out  DATA_W; mem_rdata  in  DATA_W; mem_ready  in  1.

Function
REQ-011 SHALL implement states IDLE, BUSY, DONE, ERR; state register in clk domain.
REQ-012 IDLE: LD_MAR loads MAR<=bus_in[ADDR_W-1:0]; LD_MDR with MIO_EN=0 loads MDR<=bus_in.
REQ-013 IDLE, MIO_EN=1, DATA_SIZE=1, MAR[LB-1:0]!=0: SHALL go to ERR without asserting mem_en; fault=1 for that one ERR cycle.
REQ-014 IDLE, MIO_EN=1, otherwise: SHALL latch R_W, DATA_SIZE and MAR[LB-1:0], clear wait counter, go to BUSY.
REQ-015 BUSY: mem_en=1, mem_addr=MAR with low LB bits forced to 0; mem_we=0 on reads.
REQ-016 BUSY word write: mem_we all ones, mem_wdata=MDR.
REQ-017 BUSY byte write: mem_we one-hot at latched byte index, mem_wdata=MDR[7:0] replicated to all NB lanes.
REQ-018 BUSY, mem_ready=1: read loads MDR<=mem_rdata in same edge; go to DONE.
REQ-019 BUSY, mem_ready=0: wait counter increments; when counter reaches WAIT_MAX with mem_ready=0, go to ERR with timeout=1 in ERR; MDR unchanged.
REQ-020 mem_ready=1 on the cycle the counter would reach WAIT_MAX SHALL take priority (DONE, no timeout).
REQ-021 DONE: R=1 for exactly one cycle, then IDLE; ERR: R=1, fault/timeout per cause, one cycle, then IDLE.
REQ-022 Latency: read/write with mem_ready in first BUSY cycle -> R asserted 2 cycles after MIO_EN sampled.
REQ-023 LD_MAR, LD_MDR, MIO_EN outside IDLE SHALL be ignored; MAR and MDR hold.
REQ-024 mdr_out: latched DATA_SIZE=1 -> MDR; DATA_SIZE=0 -> byte MDR[8*i+7:8*i] at i=MAR[LB-1:0], sign-extended to DATA_W.
REQ-025 mem_ready outside BUSY SHALL be ignored.
REQ-026 Wait counter width SHALL be clog2(WAIT_MAX+1); no wrap.

Reset
REQ-027 rst=0 SHALL immediately force state IDLE, MAR=0, MDR=0, counter=0, R=0, fault=0, timeout=0, mem_en=0, mem_we=0.
REQ-028 Reset mid-BUSY SHALL drop mem_en and mem_we asynchronously; no R pulse after release.
REQ-029 First access after reset release SHALL require MIO_EN sampled high at a rising edge with rst=1.

Verification
REQ-030 Word read: MAR=0x3000, MIO_EN=1 R_W=0 DATA_SIZE=1, mem_ready next cycle with mem_rdata=0xBEEF -> mem_addr=0x3000, MDR=0xBEEF, R one cycle, mdr_out=0xBEEF.
REQ-031 Byte write odd: MAR=0x3001, MDR=0x12A5, DATA_SIZE=0 R_W=1 -> mem_we=2'b10, mem_wdata=0xA5A5, mem_addr=0x3000, R after ready.
REQ-032 Byte read sign-extend: MAR=0x4001, mem_rdata=0x80FF -> mdr_out=0xFF80; MAR=0x4000 -> 0xFFFF.
REQ-033 Unaligned word: MAR=0x2003, DATA_SIZE=1, MIO_EN=1 -> mem_en never 1, fault=1 and R=1 one cycle, MDR unchanged.
REQ-034 Timeout: mem_ready held 0, WAIT_MAX=15 -> timeout=1 and R=1 after 15 BUSY cycles; mem_ready=1 on the 15th BUSY cycle instead -> R, no timeout.
REQ-035 Reset mid-access: rst=0 during BUSY -> mem_en=0 same cycle, MAR=0, MDR=0; LD_MAR during BUSY leaves MAR unchanged (separate run).
